// File: rtl/tetris_pkg.sv
// Shared types and board constants for the falling-piece controller.
// Imported by the arbiter and the piece controller.
package tetris_pkg;

  localparam int BOARD_W = 10;
  localparam int BOARD_H = 20;
  localparam int SPAWN_X = 4;
  localparam int SPAWN_Y = 0;

  typedef enum logic [2:0] {
    IDLE,
    SPAWN_CHK,
    READY,
    CHECK,
    LOCK
  } state_e;

  typedef enum logic [1:0] {
    ACT_ROT,
    ACT_LEFT,
    ACT_RIGHT,
    ACT_GRAV
  } act_e;

endpackage

// File: rtl/action_arbiter.sv
// Pending-request flags, one per action source, with a fixed
// priority select (rot > left > right > gravity).
module action_arbiter
  import tetris_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr_all,
  input  logic rot_i,
  input  logic left_i,
  input  logic right_i,
  input  logic grav_i,
  input  logic sel_take,
  output logic act_valid,
  output act_e act_code
);

  logic [3:0] pend_q, pend_d;
  logic [3:0] req;
  logic [3:0] sel;

  assign req = {grav_i, right_i, left_i, rot_i};
  // isolate the lowest set bit: bit 0 is the highest priority
  assign sel = pend_q & ~(pend_q - 4'd1);
  assign act_valid = |pend_q;

  always_comb begin
    act_code = ACT_ROT;
    unique case (1'b1)
      sel[0]:  act_code = ACT_ROT;
      sel[1]:  act_code = ACT_LEFT;
      sel[2]:  act_code = ACT_RIGHT;
      sel[3]:  act_code = ACT_GRAV;
      default: act_code = ACT_ROT;
    endcase
  end

  always_comb begin
    pend_d = (pend_q | (req & {4{en}}))
           & ~(sel & {4{sel_take}});
    if (clr_all) pend_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= '0;
    else        pend_q <= pend_d;
  end

endmodule

// File: rtl/piece_controller.sv
// Active-piece owner: arbitrates move requests, validates them with
// the board checker via req/ack, then commits, rejects or locks.
module piece_controller
  import tetris_pkg::*;
#(
  parameter int BOARD_W = tetris_pkg::BOARD_W,
  parameter int BOARD_H = tetris_pkg::BOARD_H,
  parameter int SPAWN_X = tetris_pkg::SPAWN_X,
  parameter int SPAWN_Y = tetris_pkg::SPAWN_Y,
  parameter int X_W     = 4,
  parameter int Y_W     = 5
)(
  input  logic           CLOCK_50,
  input  logic           resetn,
  input  logic           left_final,
  input  logic           right_final,
  input  logic           rot_final,
  input  logic           tick_gravity,
  input  logic           spawn,
  input  logic [2:0]     piece_type,
  output logic           chk_req,
  output logic [X_W-1:0] chk_x,
  output logic [Y_W-1:0] chk_y,
  output logic [1:0]     chk_rot,
  output logic [2:0]     chk_type,
  input  logic           chk_ack,
  input  logic           chk_ok,
  output logic [X_W-1:0] piece_x,
  output logic [Y_W-1:0] piece_y,
  output logic [1:0]     piece_rot,
  output logic           piece_active,
  output logic           lock,
  output logic           spawn_fail,
  output logic           busy
);

  localparam logic [X_W-1:0] X_MAX = X_W'(BOARD_W - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(BOARD_H - 1);
  localparam logic [X_W-1:0] X_SPN = X_W'(SPAWN_X);
  localparam logic [Y_W-1:0] Y_SPN = Y_W'(SPAWN_Y);

  state_e         state_q, state_d;
  act_e           act_q, act_d;
  logic [X_W-1:0] cx_q, cx_d, px_q, px_d;
  logic [Y_W-1:0] cy_q, cy_d, py_q, py_d;
  logic [1:0]     cr_q, cr_d, pr_q, pr_d;
  logic [2:0]     type_q, type_d;
  logic           act_on_q, act_on_d;
  logic           fail_q, fail_d;

  logic           sel_take;
  logic           act_valid;
  act_e           act_code;
  logic           arb_en;
  logic           arb_clr;

  assign arb_en  = (state_q == READY) || (state_q == CHECK)
                || (state_q == LOCK);
  assign arb_clr = (state_q == LOCK);

  action_arbiter u_arb (
    .clk       (CLOCK_50),
    .rst_n     (resetn),
    .en        (arb_en),
    .clr_all   (arb_clr),
    .rot_i     (rot_final),
    .left_i    (left_final),
    .right_i   (right_final),
    .grav_i    (tick_gravity),
    .sel_take  (sel_take),
    .act_valid (act_valid),
    .act_code  (act_code)
  );

  always_comb begin
    state_d  = state_q;
    act_d    = act_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    cr_d     = cr_q;
    px_d     = px_q;
    py_d     = py_q;
    pr_d     = pr_q;
    type_d   = type_q;
    act_on_d = act_on_q;
    fail_d   = 1'b0;
    sel_take = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (spawn) begin
          type_d  = piece_type;
          cx_d    = X_SPN;
          cy_d    = Y_SPN;
          cr_d    = 2'd0;
          state_d = SPAWN_CHK;
        end
      end
      SPAWN_CHK: begin
        if (chk_ack) begin
          if (chk_ok) begin
            px_d     = cx_q;
            py_d     = cy_q;
            pr_d     = cr_q;
            act_on_d = 1'b1;
            state_d  = READY;
          end else begin
            fail_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      READY: begin
        if (act_valid) begin
          sel_take = 1'b1;
          act_d    = act_code;
          cx_d     = px_q;
          cy_d     = py_q;
          cr_d     = pr_q;
          unique case (act_code)
            ACT_ROT: begin
              cr_d    = pr_q + 2'd1;
              state_d = CHECK;
            end
            ACT_LEFT: begin
              if (px_q != '0) begin
                cx_d    = px_q - 1'b1;
                state_d = CHECK;
              end
            end
            ACT_RIGHT: begin
              if (px_q != X_MAX) begin
                cx_d    = px_q + 1'b1;
                state_d = CHECK;
              end
            end
            ACT_GRAV: begin
              // already on the floor: no check needed, it lands
              if (py_q == Y_MAX) begin
                act_on_d = 1'b0;
                state_d  = LOCK;
              end else begin
                cy_d    = py_q + 1'b1;
                state_d = CHECK;
              end
            end
          endcase
        end
      end
      CHECK: begin
        if (chk_ack) begin
          if (chk_ok) begin
            px_d    = cx_q;
            py_d    = cy_q;
            pr_d    = cr_q;
            state_d = READY;
          end else if (act_q == ACT_GRAV) begin
            act_on_d = 1'b0;
            state_d  = LOCK;
          end else begin
            state_d = READY;
          end
        end
      end
      LOCK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      act_q    <= ACT_ROT;
      cx_q     <= '0;
      cy_q     <= '0;
      cr_q     <= '0;
      px_q     <= '0;
      py_q     <= '0;
      pr_q     <= '0;
      type_q   <= '0;
      act_on_q <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      act_q    <= act_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      cr_q     <= cr_d;
      px_q     <= px_d;
      py_q     <= py_d;
      pr_q     <= pr_d;
      type_q   <= type_d;
      act_on_q <= act_on_d;
      fail_q   <= fail_d;
    end
  end

  assign chk_req      = (state_q == SPAWN_CHK) || (state_q == CHECK);
  assign chk_x        = cx_q;
  assign chk_y        = cy_q;
  assign chk_rot      = cr_q;
  assign chk_type     = type_q;
  assign piece_x      = px_q;
  assign piece_y      = py_q;
  assign piece_rot    = pr_q;
  assign piece_active = act_on_q;
  assign lock         = (state_q == LOCK);
  assign spawn_fail   = fail_q;
  assign busy         = (state_q != IDLE) && (state_q != READY);

endmodule

// File: tb/tb_piece_controller.sv
// Bench for piece_controller: behavioural checker, directed table,
// corner sequences and a randomized run against a request-level model.
module tb_piece_controller;

  logic       CLOCK_50 = 1'b0;
  logic       resetn;
  logic       left_final, right_final, rot_final, tick_gravity;
  logic       spawn;
  logic [2:0] piece_type;
  logic       chk_req;
  logic [3:0] chk_x;
  logic [4:0] chk_y;
  logic [1:0] chk_rot;
  logic [2:0] chk_type;
  logic       chk_ack, chk_ok;
  logic [3:0] piece_x;
  logic [4:0] piece_y;
  logic [1:0] piece_rot;
  logic       piece_active, lock, spawn_fail, busy;

  always #5 CLOCK_50 = ~CLOCK_50;

  piece_controller dut (
    .CLOCK_50     (CLOCK_50),
    .resetn       (resetn),
    .left_final   (left_final),
    .right_final  (right_final),
    .rot_final    (rot_final),
    .tick_gravity (tick_gravity),
    .spawn        (spawn),
    .piece_type   (piece_type),
    .chk_req      (chk_req),
    .chk_x        (chk_x),
    .chk_y        (chk_y),
    .chk_rot      (chk_rot),
    .chk_type     (chk_type),
    .chk_ack      (chk_ack),
    .chk_ok       (chk_ok),
    .piece_x      (piece_x),
    .piece_y      (piece_y),
    .piece_rot    (piece_rot),
    .piece_active (piece_active),
    .lock         (lock),
    .spawn_fail   (spawn_fail),
    .busy         (busy)
  );

  typedef struct {
    int x;
    int y;
    int r;
    int t;
  } cand_t;

  typedef struct {
    logic rot, l, r, g, ok;
    int ex, ey, er, ea, el;
  } vec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   ck_wait  = 0;
  logic default_ok = 1'b1;
  logic ok_q[$];
  cand_t log_q[$];
  int   lock_cnt = 0;
  int   fail_cnt = 0;
  int   req_cnt  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // behavioural checker: acks ck_wait cycles after seeing chk_req
  initial begin
    int wcnt;
    wcnt = 0;
    chk_ack = 1'b0;
    chk_ok  = 1'b0;
    forever begin
      @(negedge CLOCK_50);
      if (chk_ack) begin
        chk_ack = 1'b0;
        chk_ok  = 1'b0;
        wcnt    = 0;
      end else if (chk_req && resetn) begin
        if (wcnt >= ck_wait) begin
          chk_ack = 1'b1;
          chk_ok  = (ok_q.size() != 0) ? ok_q.pop_front() : default_ok;
          log_q.push_back('{int'(chk_x), int'(chk_y),
                            int'(chk_rot), int'(chk_type)});
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge CLOCK_50);
      lock_cnt += int'(lock);
      fail_cnt += int'(spawn_fail);
      req_cnt  += int'(chk_req);
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic pulse(input logic r_, input logic l_,
                       input logic rt_, input logic g_);
    @(negedge CLOCK_50);
    rot_final    = r_;
    left_final   = l_;
    right_final  = rt_;
    tick_gravity = g_;
    @(negedge CLOCK_50);
    rot_final    = 1'b0;
    left_final   = 1'b0;
    right_final  = 1'b0;
    tick_gravity = 1'b0;
  endtask

  task automatic do_spawn(input int t, input logic ok);
    ok_q.push_back(ok);
    @(negedge CLOCK_50);
    spawn      = 1'b1;
    piece_type = 3'(t);
    @(negedge CLOCK_50);
    spawn = 1'b0;
    wait_cycles(ck_wait + 5);
  endtask

  task automatic check_piece(input string n, input int x,
                             input int y, input int r);
    check({n, "_x"}, int'(piece_x), x);
    check({n, "_y"}, int'(piece_y), y);
    check({n, "_rot"}, int'(piece_rot), r);
  endtask

  vec_t tbl[6];

  initial begin
    int l0, r0, f0;
    int mx, my, mr;
    logic mact;
    cand_t exp_q[$];

    resetn = 1'b0;
    left_final = 0; right_final = 0; rot_final = 0;
    tick_gravity = 0; spawn = 0; piece_type = 0;

    tbl[0] = '{1, 0, 0, 0, 1, 3, 0, 1, 1, 0};
    tbl[1] = '{1, 0, 1, 0, 1, 4, 0, 2, 1, 0};
    tbl[2] = '{0, 1, 0, 0, 0, 4, 0, 2, 1, 0};
    tbl[3] = '{0, 0, 0, 1, 1, 4, 1, 2, 1, 0};
    tbl[4] = '{1, 1, 1, 1, 1, 4, 2, 3, 1, 0};
    tbl[5] = '{0, 0, 0, 1, 0, 4, 2, 3, 0, 1};

    // reset state
    #23;
    check("rst_outputs",
          int'({chk_req, chk_x, chk_y, chk_rot, chk_type, piece_x,
                piece_y, piece_rot, piece_active, lock, spawn_fail, busy}), 0);
    @(negedge CLOCK_50);
    resetn = 1'b1;
    wait_cycles(2);

    // spawn with a two-cycle checker
    ck_wait = 2;
    ok_q.push_back(1'b1);
    @(negedge CLOCK_50);
    spawn = 1'b1;
    piece_type = 3'd3;
    @(negedge CLOCK_50);
    spawn = 1'b0;
    check("spawn_req", int'(chk_req), 1);
    check("spawn_chk_x", int'(chk_x), 4);
    check("spawn_chk_y", int'(chk_y), 0);
    check("spawn_chk_type", int'(chk_type), 3);
    check("spawn_busy", int'(busy), 1);
    wait_cycles(6);
    check("spawn_active", int'(piece_active), 1);
    check_piece("spawn", 4, 0, 0);
    check("spawn_lock", lock_cnt, 0);
    check("spawn_fail", fail_cnt, 0);

    // latency with a zero-wait checker
    ck_wait = 0;
    pulse(0, 1, 0, 0);
    @(posedge CLOCK_50);
    #1;
    check("lat_req", int'(chk_req), 1);
    check("lat_chk_x", int'(chk_x), 3);
    check("lat_x_before", int'(piece_x), 4);
    @(posedge CLOCK_50);
    #1;
    check("lat_x_after", int'(piece_x), 3);
    l0 = lock_cnt;
    ok_q.push_back(1'b0);
    pulse(0, 1, 0, 0);
    wait_cycles(6);
    check("left_nok_x", int'(piece_x), 3);
    check("left_nok_lock", lock_cnt - l0, 0);

    // directed table from (3,0,0)
    for (int i = 0; i < 6; i++) begin
      default_ok = tbl[i].ok;
      l0 = lock_cnt;
      pulse(tbl[i].rot, tbl[i].l, tbl[i].r, tbl[i].g);
      wait_cycles(20);
      check_piece($sformatf("tbl%0d", i), tbl[i].ex, tbl[i].ey, tbl[i].er);
      check($sformatf("tbl%0d_active", i), int'(piece_active), tbl[i].ea);
      check($sformatf("tbl%0d_lock", i), lock_cnt - l0, tbl[i].el);
    end
    default_ok = 1'b1;

    // wall boundaries
    do_spawn(1, 1'b1);
    repeat (4) begin pulse(0, 1, 0, 0); wait_cycles(5); end
    check("wall_l_x", int'(piece_x), 0);
    r0 = req_cnt;
    pulse(0, 1, 0, 0);
    wait_cycles(6);
    check("wall_l_noreq", req_cnt - r0, 0);
    check("wall_l_x2", int'(piece_x), 0);
    repeat (9) begin pulse(0, 0, 1, 0); wait_cycles(5); end
    check("wall_r_x", int'(piece_x), 9);
    r0 = req_cnt;
    pulse(0, 0, 1, 0);
    wait_cycles(6);
    check("wall_r_noreq", req_cnt - r0, 0);
    check("wall_r_x2", int'(piece_x), 9);
    pulse(0, 1, 0, 0);
    wait_cycles(6);
    check("wall_flag_clear", int'(piece_x), 8);

    // floor: gravity at the bottom row locks without a check
    repeat (19) begin pulse(0, 0, 0, 1); wait_cycles(5); end
    check("floor_y", int'(piece_y), 19);
    r0 = req_cnt;
    l0 = lock_cnt;
    pulse(0, 0, 0, 1);
    wait_cycles(6);
    check("floor_noreq", req_cnt - r0, 0);
    check("floor_lock", lock_cnt - l0, 1);
    check("floor_active", int'(piece_active), 0);
    check("floor_y_hold", int'(piece_y), 19);

    // simultaneous rot + right from (4,5,3)
    do_spawn(2, 1'b1);
    repeat (5) begin pulse(0, 0, 0, 1); wait_cycles(5); end
    repeat (3) begin pulse(1, 0, 0, 0); wait_cycles(5); end
    check_piece("pre_pair", 4, 5, 3);
    log_q.delete();
    pulse(1, 0, 1, 0);
    wait_cycles(12);
    check("pair_nchecks", log_q.size(), 2);
    if (log_q.size() == 2) begin
      check("pair_c0_rot", log_q[0].r, 0);
      check("pair_c0_x", log_q[0].x, 4);
      check("pair_c1_x", log_q[1].x, 5);
      check("pair_c1_rot", log_q[1].r, 0);
    end
    check_piece("pair", 5, 5, 0);

    // gravity rejected with left pending
    l0 = lock_cnt;
    ok_q.push_back(1'b1);
    ok_q.push_back(1'b0);
    pulse(0, 1, 0, 1);
    wait_cycles(15);
    check("gl_x", int'(piece_x), 4);
    check("gl_lock", lock_cnt - l0, 1);
    check("gl_active", int'(piece_active), 0);
    check("gl_busy", int'(busy), 0);
    r0 = req_cnt;
    wait_cycles(10);
    check("gl_noreq", req_cnt - r0, 0);

    // blocked spawn
    f0 = fail_cnt;
    do_spawn(6, 1'b0);
    check("sf_pulse", fail_cnt - f0, 1);
    check("sf_active", int'(piece_active), 0);
    check("sf_busy", int'(busy), 0);

    // asynchronous reset in the middle of a check
    do_spawn(5, 1'b1);
    ck_wait = 6;
    pulse(0, 1, 0, 0);
    wait_cycles(3);
    check("mid_req", int'(chk_req), 1);
    #3;
    resetn = 1'b0;
    #1;
    check("mid_rst_outputs",
          int'({chk_req, chk_x, chk_y, chk_rot, chk_type, piece_x,
                piece_y, piece_rot, piece_active, lock, spawn_fail, busy}), 0);
    wait_cycles(2);
    resetn = 1'b1;
    ck_wait = 0;
    ok_q.delete();
    wait_cycles(2);

    // randomized bursts against a request-level model
    mact = 1'b0;
    mx = 0; my = 0; mr = 0;
    for (int it = 0; it < 120; it++) begin
      logic [3:0] bits;
      int t;
      ck_wait = int'($urandom_range(0, 2));
      if (!mact) begin
        t = int'($urandom_range(0, 7));
        do_spawn(t, 1'b1);
        mact = 1'b1; mx = 4; my = 0; mr = 0;
      end
      bits = 4'($urandom);
      bits[3] = ($urandom_range(0, 3) == 0);
      exp_q.delete();
      log_q.delete();
      l0 = lock_cnt;
      // service in priority order: rot, left, right, gravity
      for (int a = 0; a < 4; a++) begin
        if (bits[a] && mact) begin
          logic ok;
          int nx, ny, nr;
          bit need;
          nx = mx; ny = my; nr = mr; need = 1;
          ok = ($urandom_range(0, 3) != 0);
          case (a)
            0: nr = (mr + 1) % 4;
            1: if (mx == 0) need = 0; else nx = mx - 1;
            2: if (mx == 9) need = 0; else nx = mx + 1;
            default: if (my == 19) begin need = 0; mact = 0; end
                     else ny = my + 1;
          endcase
          if (need) begin
            ok_q.push_back(ok);
            exp_q.push_back('{nx, ny, nr, int'(chk_type)});
            if (ok) begin mx = nx; my = ny; mr = nr; end
            else if (a == 3) mact = 0;
          end
        end
      end
      pulse(bits[0], bits[1], bits[2], bits[3]);
      wait_cycles(30);
      check("rnd_nchecks", log_q.size(), exp_q.size());
      for (int k = 0; k < exp_q.size() && k < log_q.size(); k++) begin
        check("rnd_cand_x", log_q[k].x, exp_q[k].x);
        check("rnd_cand_y", log_q[k].y, exp_q[k].y);
        check("rnd_cand_rot", log_q[k].r, exp_q[k].r);
      end
      check_piece("rnd", mx, my, mr);
      check("rnd_active", int'(piece_active), int'(mact));
      check("rnd_lock", lock_cnt - l0, mact ? 0 : 1);
      if (!mact) ok_q.delete();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
